// File: rtl/ysyx_25070198_sram.sv
// rtl/ysyx_25070198_sram.sv - single-port word SRAM with fixed or LFSR-driven response latency
module ysyx_25070198_sram #(
    parameter int         ADDR_W    = 10,
    parameter int         RAND_LAT  = 0,
    parameter int         LATENCY   = 2,
    parameter logic [3:0] LFSR_SEED = 4'b1001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic [31:0] lsu_rdata,
    output logic        lsu_respValid
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        lfsr_q, lfsr_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       rd_word;
    logic [3:0]        delay;
    logic              accept;
    logic              unused_addr_bits;

    assign req_idx          = lsu_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{lsu_addr[31:ADDR_W+2], lsu_addr[1:0]};
    assign accept           = rst && (state_q == ST_IDLE) && lsu_reqValid;
    assign delay            = (RAND_LAT != 0) ? ({1'b0, lfsr_q[2:0]} + 4'd1) : 4'(LATENCY);

    // In IDLE the response (D=1) must see the incoming index, later the latched one
    assign rd_idx  = (state_q == ST_IDLE) ? req_idx : idx_q;
    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (accept && lsu_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (lsu_wmask[i]) begin
                    mem[req_idx][8*i +: 8] <= lsu_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wen_d        = wen_q;
        idx_d        = idx_q;
        resp_valid_d = 1'b0;
        rdata_d      = 32'h0;
        lfsr_d       = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wen_d = lsu_wen;
                    idx_d = req_idx;
                    if (delay == 4'd1) begin
                        state_d      = ST_RESP;
                        cnt_d        = 3'd0;
                        resp_valid_d = 1'b1;
                        rdata_d      = lsu_wen ? 32'h0 : rd_word;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 3'(delay - 4'd1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 3'd1) begin
                    state_d      = ST_RESP;
                    cnt_d        = 3'd0;
                    resp_valid_d = 1'b1;
                    rdata_d      = wen_q ? 32'h0 : rd_word;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            wen_q        <= 1'b0;
            idx_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wen_q        <= wen_d;
            idx_q        <= idx_d;
            lfsr_q       <= lfsr_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign lsu_respValid = resp_valid_q;
    assign lsu_rdata     = rdata_q;
endmodule

// File: tb/tb_ysyx_25070198_sram.sv
// tb/tb_ysyx_25070198_sram.sv - directed and randomized bench for ysyx_25070198_sram
module tb_ysyx_25070198_sram;
    localparam logic [3:0] SEED = 4'b1001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_a, wen_a, resp_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  wmask_a;
    logic        rst_b, req_b, wen_b, resp_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  wmask_b;

    ysyx_25070198_sram #(.ADDR_W(10), .RAND_LAT(0), .LATENCY(2), .LFSR_SEED(SEED)) dut_fixed (
        .clk(clk), .rst(rst_a), .lsu_reqValid(req_a), .lsu_addr(addr_a), .lsu_wen(wen_a),
        .lsu_wdata(wdata_a), .lsu_wmask(wmask_a), .lsu_rdata(rdata_a), .lsu_respValid(resp_a)
    );

    ysyx_25070198_sram #(.ADDR_W(10), .RAND_LAT(1), .LATENCY(2), .LFSR_SEED(SEED)) dut_rand (
        .clk(clk), .rst(rst_b), .lsu_reqValid(req_b), .lsu_addr(addr_b), .lsu_wen(wen_b),
        .lsu_wdata(wdata_b), .lsu_wmask(wmask_b), .lsu_rdata(rdata_b), .lsu_respValid(resp_b)
    );

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    int          hist [1:8];
    int          checks = 0;
    int          errors = 0;

    // Reference for the latency source: x^4+x^3+1 sequence advancing once per clock out of reset
    logic [3:0] lfsr_m;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) lfsr_m <= SEED;
        else        lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic [31:0] addr,
                         input logic wen, input logic [31:0] wdata, input logic [3:0] wmask);
        if (sel) begin
            req_b = req; addr_b = addr; wen_b = wen; wdata_b = wdata; wmask_b = wmask;
        end else begin
            req_a = req; addr_a = addr; wen_a = wen; wdata_a = wdata; wmask_a = wmask;
        end
    endtask

    function automatic logic resp_of(input bit sel);
        return sel ? resp_b : resp_a;
    endfunction

    function automatic logic [31:0] rdata_of(input bit sel);
        return sel ? rdata_b : rdata_a;
    endfunction

    // Call at a falling edge with the target DUT idle; returns at a falling edge, request dropped
    task automatic txn(input bit sel, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input bit wiggle, input string tag);
        int          exp_lat;
        int          lat;
        bit          got;
        logic [9:0]  idx;
        logic [31:0] exp_rd;
        logic [31:0] rd_obs;
        logic [31:0] junk;
        idx     = addr[11:2];
        exp_lat = sel ? int'(lfsr_m[2:0]) + 1 : 2;
        exp_rd  = 32'h0;
        if (!wen) exp_rd = sel ? mem_b[idx] : mem_a[idx];
        if (wen) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    if (sel) mem_b[idx][8*b +: 8] = wdata[8*b +: 8];
                    else     mem_a[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        drive(sel, 1'b1, addr, wen, wdata, wmask);
        @(posedge clk);
        got    = 1'b0;
        lat    = 0;
        rd_obs = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            if (!got) begin
                @(negedge clk);
                if (k == 1) begin
                    junk = wiggle ? $urandom : addr;
                    drive(sel, !wiggle, junk, 1'b0, 32'h0, 4'h0);
                end
                if (resp_of(sel)) begin
                    got    = 1'b1;
                    lat    = k;
                    rd_obs = rdata_of(sel);
                    drive(sel, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
                end else begin
                    chk($sformatf("%s wait-rdata", tag), rdata_of(sel), 32'h0);
                end
            end
        end
        chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        if (got) chk($sformatf("%s rdata", tag), rd_obs, exp_rd);
        if (sel && lat >= 1 && lat <= 8) hist[lat]++;
        @(negedge clk);
        chk($sformatf("%s single-pulse", tag), 32'(resp_of(sel)), 32'h0);
    endtask

    initial begin
        logic [3:0]  idx4;
        logic [31:0] r;
        logic [31:0] addr;
        for (int l = 1; l <= 8; l++) hist[l] = 0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset resp_a", 32'(resp_a), 32'h0);
        chk("reset rdata_a", rdata_a, 32'h0);
        chk("reset resp_b", 32'(resp_b), 32'h0);
        chk("reset rdata_b", rdata_b, 32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        txn(1'b0, 32'h8, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, "wr_full");
        txn(1'b0, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, "rd_full");
        txn(1'b0, 32'h8, 1'b1, 32'h000000AA, 4'b0001, 1'b0, "wr_lane0");
        txn(1'b0, 32'h8, 1'b0, 32'h0, 4'h0, 1'b1, "rd_lane0_drop_req");
        txn(1'b0, 32'h8, 1'b1, 32'h12345678, 4'h0, 1'b0, "wr_nomask");
        txn(1'b0, 32'h0010_0008, 1'b0, 32'h0, 4'h0, 1'b0, "rd_alias");

        drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 4'h0);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
            chk($sformatf("b2b resp k=%0d", k), 32'(resp_a), 32'((k == 2) || (k == 5)));
            chk($sformatf("b2b rdata k=%0d", k), rdata_a,
                ((k == 2) || (k == 5)) ? 32'hDEADBEAA : 32'h0);
        end

        drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("rst busy resp", 32'(resp_a), 32'h0);
        chk("rst busy rdata", rdata_a, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst held resp %0d", k), 32'(resp_a), 32'h0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        rst_a = 1'b1;
        txn(1'b0, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, "rd_after_rst");

        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 32'(i * 4), 1'b1, $urandom, 4'hF, 1'b0, "rand_init");
        end
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            idx4 = 4'($urandom_range(0, 15));
            r    = $urandom;
            addr = {r[31:12], 6'b0, idx4, r[1:0]};
            txn(1'b1, addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end
        for (int l = 1; l <= 8; l++) begin
            chk($sformatf("latency %0d observed", l), 32'(hist[l] > 0), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_25070198_sram.md
YSYX_25070198_SRAM -- requirements
Module: ysyx_25070198_sram

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_W, 10, word-index width; array depth 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter RAND_LAT, 0, 0 = fixed latency, 1 = LFSR-derived latency.
REQ-003 SHALL have parameter LATENCY, 2, fixed-mode cycles from acceptance to response; legal range 1..8.
REQ-004 SHALL have parameter LFSR_SEED, 4'b1001, LFSR reset value; must be nonzero.
Ports:
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port lsu_reqValid, input, 1, initiator request valid, held high until response.
REQ-008 SHALL have port lsu_addr, input, 32, byte address; index = lsu_addr[ADDR_W+1:2]; other bits ignored.
REQ-009 SHALL have port lsu_wen, input, 1, 1 = write, 0 = read; sampled only at acceptance.
REQ-010 SHALL have port lsu_wdata, input, 32, write data; sampled only at acceptance.
REQ-011 SHALL have port lsu_wmask, input, 4, byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port lsu_rdata, output, 32, read data; valid only while lsu_respValid=1.
REQ-013 SHALL have port lsu_respValid, output, 1, single-cycle response strobe.

Function
REQ-014 SHALL implement states IDLE, BUSY and RESP.
REQ-015 SHALL accept a request in any IDLE cycle with lsu_reqValid=1 (acceptance cycle T).
REQ-016 SHALL latch wen and index at the end of T, because the initiator zeroes wen/wdata/wmask after T.
REQ-017 SHALL commit a write at the clock edge ending T, updating only lanes with wmask=1; wmask=0 writes nothing but still responds.
REQ-018 SHALL set delay D = LATENCY when RAND_LAT=0, or D = lfsr[2:0]+1 (range 1..8) sampled in T when RAND_LAT=1.
REQ-019 SHALL step the 4-bit LFSR (taps x^4+x^3+1) every cycle outside reset, regardless of state.
REQ-020 SHALL move from IDLE to RESP when D=1, and to BUSY otherwise, loading a down-counter with D-1.
REQ-021 SHALL decrement the counter each BUSY cycle, moving to RESP when it reaches 1.
REQ-022 SHALL drive lsu_respValid=1 for exactly one cycle, T+D, in RESP, then return to IDLE unconditionally.
REQ-023 SHALL register read data on entry to RESP as mem[index]; for a write, rdata SHALL be 32'h0.
REQ-024 SHALL drive lsu_respValid=0 and lsu_rdata=0 in IDLE and BUSY.
REQ-025 SHALL ignore lsu_reqValid, lsu_addr and write inputs during BUSY and RESP; dropping reqValid does not abort the transaction.
REQ-026 SHALL accept a new request in the IDLE cycle directly after RESP, giving back-to-back transactions with no bubble beyond that cycle.
REQ-027 SHALL return a read after a write to the same index with the written data, since the write commits at acceptance.
REQ-028 SHALL give the same behaviour for all addresses; no error response exists, and out-of-range upper bits alias.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, counter 0, lsu_respValid=0, lsu_rdata=0 and LFSR=LFSR_SEED, independent of clk.
REQ-030 SHALL, on reset mid-transaction, drop the pending response without emitting it.
REQ-031 SHALL keep a write committed before reset; array contents are not reset.
REQ-032 SHALL, after reset release, accept a request on the first rising edge with lsu_reqValid=1.

Verification
REQ-033 SHALL cover: fixed LATENCY=2, write addr 0x8, wdata 0xDEADBEEF, wmask 4'hF at T -> respValid at T+2 only, rdata 0.
REQ-034 SHALL cover: read addr 0x8 after the REQ-033 write -> respValid 2 cycles after acceptance, rdata 0xDEADBEEF.
REQ-035 SHALL cover: write wdata 0x000000AA, wmask 4'b0001 to addr 0x8, then read it -> rdata 0xDEADBEAA.
REQ-036 SHALL cover: back-to-back reads with reqValid held high -> responses at T+2 and T+5, one pulse each.
REQ-037 SHALL cover: RAND_LAT=1, 200 random transactions -> every latency in 1..8, each observed at least once; data matches a reference model.
REQ-038 SHALL cover: rst low in BUSY of a read -> respValid stays 0; memory intact; the next read after release returns the correct data.
